// File: rtl/program_loader.sv
// Boot loader: receives a checksummed {addr, hi, lo} record stream over valid/ready,
// writes each record into the computer's memory, then runs the computer until done or timeout.
module program_loader #(
    parameter int          ADDR_W  = 8,
    parameter int          DATA_W  = 16,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] addr_tb,
    output logic [DATA_W-1:0] data_tb,
    output logic              we_tb,
    output logic              cpu_on,
    input  logic              done,
    output logic              busy,
    output logic              load_ok,
    output logic [1:0]        error,
    output logic [7:0]        word_cnt
);

    // Handshake: a byte moves on a rising edge where rx_valid && rx_ready; the sender
    // holds rx_data stable while rx_valid is high and rx_ready is low.

    typedef enum logic [3:0] {
        IDLE,
        GET_CNT,
        GET_ADDR,
        GET_HI,
        GET_LO,
        WRITE,
        GET_CSUM,
        RUN,
        FINISH,
        FAIL
    } state_t;

    state_t      state, state_next;
    logic [7:0]  cnt_r;
    logic [7:0]  addr_r;
    logic [7:0]  hi_r;
    logic [7:0]  csum;
    logic [31:0] run_cnt;
    logic        timed_out;

    assign timed_out = (TIMEOUT != 0) && (run_cnt == TIMEOUT - 32'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rx_ready   = 1'b0;
        we_tb      = 1'b0;
        cpu_on     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_next = GET_CNT;
            end
            GET_CNT: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = (rx_data == 8'd0) ? GET_CSUM : GET_ADDR;
            end
            GET_ADDR: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = GET_HI;
            end
            GET_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = GET_LO;
            end
            GET_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = WRITE;
            end
            WRITE: begin
                we_tb      = 1'b1;
                state_next = (word_cnt + 8'd1 == cnt_r) ? GET_CSUM : GET_ADDR;
            end
            GET_CSUM: begin
                rx_ready = 1'b1;
                if (rx_valid) state_next = (rx_data == csum) ? RUN : FAIL;
            end
            RUN: begin
                cpu_on = 1'b1;
                // done takes priority over a timeout landing in the same cycle
                if (done) state_next = FINISH;
                else if (timed_out) state_next = FAIL;
            end
            FINISH:  state_next = IDLE;
            FAIL:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r    <= '0;
            addr_r   <= '0;
            hi_r     <= '0;
            csum     <= '0;
            run_cnt  <= '0;
            addr_tb  <= '0;
            data_tb  <= '0;
            word_cnt <= '0;
            load_ok  <= 1'b0;
            error    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        load_ok  <= 1'b0;
                        error    <= 2'd0;
                        word_cnt <= '0;
                        csum     <= '0;
                    end
                end
                GET_CNT: begin
                    if (rx_valid) begin
                        cnt_r <= rx_data;
                        csum  <= csum ^ rx_data;
                    end
                end
                GET_ADDR: begin
                    if (rx_valid) begin
                        addr_r <= rx_data;
                        csum   <= csum ^ rx_data;
                    end
                end
                GET_HI: begin
                    if (rx_valid) begin
                        hi_r <= rx_data;
                        csum <= csum ^ rx_data;
                    end
                end
                GET_LO: begin
                    // Outputs load here so they are valid during WRITE and hold afterwards
                    if (rx_valid) begin
                        addr_tb <= ADDR_W'(addr_r);
                        data_tb <= DATA_W'({hi_r, rx_data});
                        csum    <= csum ^ rx_data;
                    end
                end
                WRITE: begin
                    word_cnt <= word_cnt + 8'd1;
                end
                GET_CSUM: begin
                    run_cnt <= '0;
                    if (rx_valid && rx_data != csum) error <= 2'd1;
                end
                RUN: begin
                    run_cnt <= run_cnt + 32'd1;
                    if (done) load_ok <= 1'b1;
                    else if (timed_out) error <= 2'd2;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a stub computer (memory + done generator),
// a byte driver, and a frame-level model predicting writes and final session status.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  addr_tb;
    logic [15:0] data_tb;
    logic        we_tb;
    logic        cpu_on;
    logic        done;
    logic        busy;
    logic        load_ok;
    logic [1:0]  error;
    logic [7:0]  word_cnt;

    localparam int TMO = 16;

    program_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .addr_tb(addr_tb), .data_tb(data_tb), .we_tb(we_tb),
        .cpu_on(cpu_on), .done(done), .busy(busy),
        .load_ok(load_ok), .error(error), .word_cnt(word_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exp_mem[256];
    logic [15:0] mem[256];
    logic [15:0] out_q[$];
    int          done_after = 0;
    int          on_cnt = 0;
    int          on_cycles = 0;
    bit          jitter = 1'b0;
    bit          outr_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- stub computer ----------------
    assign done = cpu_on && (done_after != 0) && (on_cnt == done_after - 1);

    always @(posedge clk) begin
        if (we_tb) mem[addr_tb] <= data_tb;
        if (cpu_on && on_cnt == 0 && outr_en)
            for (int i = 0; i < 5; i++) out_q.push_back(mem[8'h30 + i]);
        on_cnt <= cpu_on ? on_cnt + 1 : 0;
    end

    // ---------------- per-cycle scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_on) on_cycles++;
            chk("we_cpu_overlap", {63'd0, we_tb & cpu_on}, 64'd0);
            if (we_tb) begin
                if (exp_q.size() == 0) chk("write_unexpected", 64'(exp_q.size()), 64'd1);
                else chk("write", {40'd0, addr_tb, data_tb}, {40'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        while (jitter && $urandom_range(0, 1) == 1) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("rx_ready_wait", {63'd0, guard < 50}, 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic build(input logic [23:0] recs[$], input logic [7:0] flip,
                         output logic [7:0] fr[$]);
        logic [7:0] x;
        fr = {};
        fr.push_back(8'(recs.size()));
        foreach (recs[i]) begin
            fr.push_back(recs[i][23:16]);
            fr.push_back(recs[i][15:8]);
            fr.push_back(recs[i][7:0]);
        end
        x = 8'd0;
        foreach (fr[i]) x = x ^ fr[i];
        fr.push_back(x ^ flip);
    endtask

    // Frame-level model: expected writes, cpu_on duration and final status
    task automatic run_session(input logic [7:0] fr[$], input int da, input string tag);
        logic [7:0] x;
        int         n;
        bit         good;
        int         exp_on;
        int         guard;
        n = fr[0];
        x = 8'd0;
        for (int i = 0; i < fr.size() - 1; i++) x = x ^ fr[i];
        good = (fr[fr.size() - 1] == x);
        for (int r = 0; r < n; r++) begin
            exp_q.push_back({fr[1 + 3 * r], fr[2 + 3 * r], fr[3 + 3 * r]});
            exp_mem[fr[1 + 3 * r]] = {fr[2 + 3 * r], fr[3 + 3 * r]};
        end
        exp_on     = !good ? 0 : (da == 0 ? TMO : da);
        done_after = da;
        on_cycles  = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        foreach (fr[i]) send_byte(fr[i]);
        chk({tag, "_cpu_on_after_csum"}, {63'd0, cpu_on}, {63'd0, good});
        guard = 0;
        while (busy && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_end_wait"}, {63'd0, guard < 200}, 64'd1);
        chk({tag, "_error"}, {62'd0, error}, !good ? 64'd1 : (da == 0 ? 64'd2 : 64'd0));
        chk({tag, "_load_ok"}, {63'd0, load_ok}, {63'd0, good && da != 0});
        chk({tag, "_word_cnt"}, {56'd0, word_cnt}, 64'(n));
        chk({tag, "_cpu_cycles"}, 64'(on_cycles), 64'(exp_on));
        chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_idle_outs"}, {61'd0, cpu_on, we_tb, rx_ready}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [23:0] recs[$];
        logic [7:0]  fr[$];
        logic [15:0] outr_exp[5];
        int          n;

        #12;
        chk("reset_outs", {25'd0, rx_ready, addr_tb, data_tb, we_tb, cpu_on, busy,
                           load_ok, error, word_cnt}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: two records, good checksum
        recs = {24'h001025, 24'h010863};
        build(recs, 8'h00, fr);
        chk("t1_csum_model", {56'd0, fr[7]}, 64'h5D);
        run_session(fr, 3, "t1");
        chk("t1_mem00", {48'd0, mem[8'h00]}, 64'h1025);
        chk("t1_mem01", {48'd0, mem[8'h01]}, 64'h0863);

        // 2: same frame, corrupted checksum
        build(recs, 8'h01, fr);
        chk("t2_csum_model", {56'd0, fr[7]}, 64'h5C);
        run_session(fr, 3, "t2");

        // 3: empty program
        recs = {};
        build(recs, 8'h00, fr);
        chk("t3_frame_model", {48'd0, fr[0], fr[1]}, 64'h0);
        run_session(fr, 2, "t3");

        // 4: never-halting program -> timeout after TMO cycles
        run_session(fr, 0, "t4");

        // 5: 24-word program plus 5 data words, ragged rx_valid
        recs = {};
        for (int i = 0; i < 24; i++) recs.push_back({8'(i), 16'(16'h7100 + i * 16'h0113)});
        outr_exp = '{16'h5487, 16'h6666, 16'h00FF, 16'h0BED, 16'hABCD};
        for (int i = 0; i < 5; i++) recs.push_back({8'(8'h30 + i), outr_exp[i]});
        build(recs, 8'h00, fr);
        jitter  = 1'b1;
        outr_en = 1'b1;
        run_session(fr, 10, "t5");
        outr_en = 1'b0;
        jitter  = 1'b0;
        n = 0;
        foreach (recs[i])
            if (mem[recs[i][23:16]] !== exp_mem[recs[i][23:16]]) n++;
        chk("t5_mem_image_mismatches", 64'(n), 64'd0);
        chk("t5_outr_count", 64'(out_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < out_q.size(); i++)
            chk("t5_outr", {48'd0, out_q[i]}, {48'd0, outr_exp[i]});

        // 6: reset while waiting for the HI byte of record 3
        recs = {24'h405555, 24'h41AAAA, 24'h42F00F, 24'h431234};
        build(recs, 8'h00, fr);
        exp_q.push_back(recs[0]);
        exp_q.push_back(recs[1]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(fr[i]);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_reset_outs", {25'd0, rx_ready, addr_tb, data_tb, we_tb, cpu_on, busy,
                              load_ok, error, word_cnt}, 64'd0);
        chk("t6_writes_before_reset", 64'(exp_q.size()), 64'd0);
        chk("t6_mem41_kept", {48'd0, mem[8'h41]}, 64'hAAAA);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        recs = {24'h001025, 24'h010863};
        build(recs, 8'h00, fr);
        run_session(fr, 4, "t6_restart");

        // random sessions
        for (int s = 0; s < 8; s++) begin
            recs = {};
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++)
                recs.push_back({8'($urandom_range(0, 15)), 16'($urandom)});
            build(recs, ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00, fr);
            jitter = 1'($urandom_range(0, 1));
            run_session(fr, ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, TMO), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
